// File: rtl/ext_share_arb.sv
// ext_share_arb
//   Shares one immediate-extension unit between the two decode issue slots.
//   Grants at most one slot per cycle, extends the winner's immediate and
//   registers the 32-bit result back to that slot one cycle later.
//
//   Build option:
//     EXT_ARB_RR_EN defined   : round-robin between slots under contention
//     EXT_ARB_RR_EN undefined : fixed priority, slot 0 wins contention
//
//   Ports:
//     clk, rst                 clock, async active-high reset
//     flush                    suppresses all grants this cycle
//     sN_req/upper/sext/imm    slot N request and operands (held until gnt)
//     sN_gnt                   combinational grant, operands consumed
//     sN_rvalid                one-cycle pulse, sN_result just updated
//     sN_result                registered per-slot result, held between pulses

module ext_share_arb #(
    parameter int IMM_W = 16,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s0_req,
    input  logic             s1_req,
    input  logic             s0_upper,
    input  logic             s1_upper,
    input  logic             s0_sext,
    input  logic             s1_sext,
    input  logic [IMM_W-1:0] s0_imm,
    input  logic [IMM_W-1:0] s1_imm,
    output logic             s0_gnt,
    output logic             s1_gnt,
    output logic             s0_rvalid,
    output logic             s1_rvalid,
    output logic [RES_W-1:0] s0_result,
    output logic [RES_W-1:0] s1_result
);

    localparam int PAD_W = RES_W - IMM_W;

    logic             pick_s1;
    logic             grant_ok;
    logic [IMM_W-1:0] sel_imm;
    logic             sel_upper;
    logic             sel_sext;
    logic [RES_W-1:0] ext_res;

`ifdef EXT_ARB_RR_EN
    // Index of the most recently granted slot; 1 out of reset so slot 0
    // wins the first contention.
    logic last_gnt;

    always_comb begin
        // Under contention slot 1 wins only if slot 0 was granted last.
        pick_s1 = s1_req & (~s0_req | ~last_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (s0_gnt) begin
            last_gnt <= 1'b0;
        end else if (s1_gnt) begin
            last_gnt <= 1'b1;
        end
    end
`else
    always_comb begin
        pick_s1 = s1_req & ~s0_req;
    end
`endif

    // Grants are forced low during reset so nothing is consumed that cannot
    // be answered.
    always_comb begin
        grant_ok = ~rst & ~flush;
        s0_gnt   = grant_ok & s0_req & ~pick_s1;
        s1_gnt   = grant_ok & pick_s1;
    end

    always_comb begin
        sel_imm   = s1_gnt ? s1_imm   : s0_imm;
        sel_upper = s1_gnt ? s1_upper : s0_upper;
        sel_sext  = s1_gnt ? s1_sext  : s0_sext;
    end

    // Shared immediate extender
    always_comb begin
        if (sel_upper) begin
            ext_res = {sel_imm, {PAD_W{1'b0}}};
        end else if (sel_sext) begin
            ext_res = {{PAD_W{sel_imm[IMM_W-1]}}, sel_imm};
        end else begin
            ext_res = {{PAD_W{1'b0}}, sel_imm};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_rvalid <= 1'b0;
            s1_rvalid <= 1'b0;
            s0_result <= '0;
            s1_result <= '0;
        end else begin
            s0_rvalid <= s0_gnt;
            s1_rvalid <= s1_gnt;
            if (s0_gnt) begin
                s0_result <= ext_res;
            end
            if (s1_gnt) begin
                s1_result <= ext_res;
            end
        end
    end

endmodule

// File: tb/tb_ext_share_arb.sv
module tb_ext_share_arb;

`ifdef EXT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        s0_req, s1_req;
    logic        s0_upper, s1_upper;
    logic        s0_sext, s1_sext;
    logic [15:0] s0_imm, s1_imm;
    logic        s0_gnt, s1_gnt;
    logic        s0_rvalid, s1_rvalid;
    logic [31:0] s0_result, s1_result;

    int n_vec = 0;
    int n_err = 0;

    ext_share_arb #(.IMM_W(16), .RES_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s0_req    (s0_req),
        .s1_req    (s1_req),
        .s0_upper  (s0_upper),
        .s1_upper  (s1_upper),
        .s0_sext   (s0_sext),
        .s1_sext   (s1_sext),
        .s0_imm    (s0_imm),
        .s1_imm    (s1_imm),
        .s0_gnt    (s0_gnt),
        .s1_gnt    (s1_gnt),
        .s0_rvalid (s0_rvalid),
        .s1_rvalid (s1_rvalid),
        .s0_result (s0_result),
        .s1_result (s1_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        s0_req = 1'b1; s1_req = 1'b0;
        s0_upper = 1'b0; s1_upper = 1'b0;
        s0_sext = 1'b0; s1_sext = 1'b0;
        s0_imm = 16'h0; s1_imm = 16'h0;

        // reset
        repeat (2) tick();
        check("rst_s0_gnt", s0_gnt, 0);
        check("rst_s1_gnt", s1_gnt, 0);
        check("rst_s0_rvalid", s0_rvalid, 0);
        check("rst_s1_rvalid", s1_rvalid, 0);
        check("rst_s0_result", s0_result, 32'h0);
        check("rst_s1_result", s1_result, 32'h0);
        rst = 1'b0; s0_req = 1'b0;
        tick();

        // contention for 4 cycles
        s0_req = 1'b1; s0_imm = 16'h8001; s0_sext = 1'b0; s0_upper = 1'b0;
        s1_req = 1'b1; s1_imm = 16'h1234; s1_sext = 1'b0; s1_upper = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_s0_gnt", s0_gnt, RR ? ((i % 2) == 0) : 1'b1);
            check("cont_s1_gnt", s1_gnt, RR ? ((i % 2) == 1) : 1'b0);
            tick();
            check("cont_s0_rvalid", s0_rvalid, RR ? ((i % 2) == 0) : 1'b1);
            check("cont_s1_rvalid", s1_rvalid, RR ? ((i % 2) == 1) : 1'b0);
        end
        check("cont_s0_result", s0_result, 32'h0000_8001);
        check("cont_s1_result", s1_result, RR ? 32'h1234_0000 : 32'h0);

        // slot 0 drops, slot 1 now granted
        s0_req = 1'b0;
        #1;
        check("solo1_s0_gnt", s0_gnt, 0);
        check("solo1_s1_gnt", s1_gnt, 1);
        tick();
        check("solo1_s1_rvalid", s1_rvalid, 1);
        check("solo1_s0_rvalid", s0_rvalid, 0);
        check("solo1_s1_result", s1_result, 32'h1234_0000);
        s1_req = 1'b0;

        // flush with both requesting for 2 cycles
        flush = 1'b1;
        s0_req = 1'b1; s0_imm = 16'hABCD; s0_sext = 1'b0; s0_upper = 1'b0;
        s1_req = 1'b1; s1_imm = 16'hFFFE; s1_sext = 1'b1; s1_upper = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("flush_s0_gnt", s0_gnt, 0);
            check("flush_s1_gnt", s1_gnt, 0);
            tick();
            check("flush_s0_rvalid", s0_rvalid, 0);
            check("flush_s1_rvalid", s1_rvalid, 0);
        end
        flush = 1'b0;
        #1;
        check("unflush_s0_gnt", s0_gnt, 1);
        check("unflush_s1_gnt", s1_gnt, 0);
        tick();
        check("unflush_s0_rvalid", s0_rvalid, 1);
        check("unflush_s0_result", s0_result, 32'h0000_ABCD);
        s0_req = 1'b0;
        #1;
        check("unflush_s1_gnt", s1_gnt, 1);
        tick();
        check("unflush_s1_rvalid", s1_rvalid, 1);
        check("unflush_s1_result", s1_result, 32'hFFFF_FFFE);
        s1_req = 1'b0;

        // single slot, sign extension
        s0_req = 1'b1; s0_imm = 16'h8001; s0_sext = 1'b1; s0_upper = 1'b0;
        #1;
        check("single_s0_gnt", s0_gnt, 1);
        check("single_s1_gnt", s1_gnt, 0);
        tick();
        check("single_s0_rvalid", s0_rvalid, 1);
        check("single_s0_result", s0_result, 32'hFFFF_8001);
        check("single_s1_result", s1_result, 32'hFFFF_FFFE);
        s0_req = 1'b0;
        tick();
        check("single_s0_rvalid_pulse", s0_rvalid, 0);
        check("single_s0_result_hold", s0_result, 32'hFFFF_8001);

        // reset asserted while slot 1 grant is in flight
        s1_req = 1'b1; s1_imm = 16'h5555; s1_sext = 1'b0; s1_upper = 1'b0;
        #1;
        check("midrst_s1_gnt_pre", s1_gnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_s1_gnt", s1_gnt, 0);
        check("midrst_s1_result_async", s1_result, 32'h0);
        tick();
        check("midrst_s1_rvalid", s1_rvalid, 0);
        check("midrst_s1_result", s1_result, 32'h0);
        rst = 1'b0; s1_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
